drum_mul_pipe: RTL and testbench

Pipelined, handshaked approximate signed multiplier using DRUM dynamic-range truncation. It generalises the combinational DRUM squarer to two independent operands with a 3-stage valid/ready pipeline and an optional per-transaction exact mode. It sits between the fixed-point geometry datapath and the shading/accumulate stages. It accepts one product per cycle at full throughput.

---
 rtl/drum_mul_pipe.sv | 185 ++++++++++++++++++
 tb/tb_drum_mul_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_mul_pipe.sv
`timescale 1ns/1ps
// drum_mul_pipe
//   Pipelined approximate signed multiplier using DRUM dynamic-range
//   truncation. Each operand keeps its K most significant bits, starting at
//   its leading one. The lowest kept bit is forced to 1 to unbias the
//   truncation. Three register stages with valid/ready flow control. The
//   block accepts one operand pair per cycle at full throughput.
//
//   Optional feature macro: DRUM_MUL_EXACT_EN
//     defined   - in_exact=1 forwards full magnitudes and S2 multiplies N x N
//     undefined - in_exact is ignored and only the K x K datapath exists
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake (in_ready independent of in_valid)
//     in_a, in_b           signed N-bit operands
//     in_exact             per-transaction exact request
//     out_valid/out_ready  result handshake
//     out_p                signed 2N-bit result, (+/-)(|a*b|_drum >> POST_SHIFT)
//     busy                 any pipeline stage occupied
module drum_mul_pipe #(
   parameter int N          = 16,
   parameter int K          = 5,
   parameter int POST_SHIFT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_exact,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_p,
   output logic             busy
);

   localparam int SHW = $clog2(N) + 1;      // per-operand shift / leading-one index
   localparam int SSW = $clog2(2 * N) + 1;  // summed shift
`ifdef DRUM_MUL_EXACT_EN
   localparam int SW  = N;                  // S1 forwards full magnitudes when exact
`else
   localparam int SW  = K;
`endif
   localparam int PW  = 2 * SW;

   function automatic logic [SHW-1:0] lead_one(input logic [N-1:0] m);
      logic [SHW-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < N; i++)
         if (m[i]) p = SHW'(i);
      return p;
   endfunction

   function automatic logic [SHW-1:0] drum_sh(input logic [SHW-1:0] p);
      return (p < SHW'(K)) ? '0 : p - SHW'(K - 1);
   endfunction

   // Below K significant bits the low K bits are the value itself.
   // Otherwise the window starts at the leading one and gets a forced LSB.
   function automatic logic [K-1:0] drum_sel(input logic [N-1:0] m,
                                             input logic [SHW-1:0] p,
                                             input logic [SHW-1:0] sh);
      logic [N-1:0] t;
      t = m >> sh;
      if (p >= SHW'(K)) t[0] = 1'b1;
      return t[K-1:0];
   endfunction

   // ---------------- stage-1 encoding (combinational) ----------------
   logic [N-1:0]   m_a, m_b;
   logic [SHW-1:0] p_a, p_b, sh_a, sh_b;
   logic [K-1:0]   sel_a, sel_b;

   always_comb begin
      m_a   = in_a[N-1] ? -in_a : in_a;
      m_b   = in_b[N-1] ? -in_b : in_b;
      p_a   = lead_one(m_a);
      p_b   = lead_one(m_b);
      sh_a  = drum_sh(p_a);
      sh_b  = drum_sh(p_b);
      sel_a = drum_sel(m_a, p_a, sh_a);
      sel_b = drum_sel(m_b, p_b, sh_b);
   end

`ifndef DRUM_MUL_EXACT_EN
   logic unused_exact;
   assign unused_exact = in_exact;
`endif

   // ---------------- handshake ----------------
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;

   assign rdy3      = !v3 || out_ready;
   assign rdy2      = !v2 || rdy3;
   assign rdy1      = !v1 || rdy2;
   assign in_ready  = rdy1;
   assign out_valid = v3;
   assign busy      = v1 | v2 | v3;

   // ---------------- S1: encoded operands ----------------
   // The exact request is resolved here into sel/sh.
   // In the exact build, a non-exact entry has zero upper sel bits.
   // The shared N x N multiplier then yields the K x K product unchanged.
   logic [SW-1:0]  a1, b1;
   logic [SHW-1:0] sha1, shb1;
   logic           neg1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         sha1 <= '0;
         shb1 <= '0;
         neg1 <= 1'b0;
      end else if (rdy1) begin
         v1 <= in_valid;
         if (in_valid) begin
`ifdef DRUM_MUL_EXACT_EN
            if (in_exact) begin
               a1   <= m_a;
               b1   <= m_b;
               sha1 <= '0;
               shb1 <= '0;
            end else begin
               a1   <= SW'(sel_a);
               b1   <= SW'(sel_b);
               sha1 <= sh_a;
               shb1 <= sh_b;
            end
`else
            a1   <= sel_a;
            b1   <= sel_b;
            sha1 <= sh_a;
            shb1 <= sh_b;
`endif
            neg1 <= in_a[N-1] ^ in_b[N-1];
         end
      end
   end

   // ---------------- S2: raw product ----------------
   logic [PW-1:0]  prod2;
   logic [SSW-1:0] sh2;
   logic           neg2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         prod2 <= '0;
         sh2   <= '0;
         neg2  <= 1'b0;
      end else if (rdy2) begin
         v2 <= v1;
         if (v1) begin
            prod2 <= PW'(a1) * PW'(b1);
            sh2   <= SSW'(sha1) + SSW'(shb1);
            neg2  <= neg1;
         end
      end
   end

   // ---------------- S3: scale, truncate, sign restore ----------------
   logic [2*N-1:0] mag, trunc, res;

   always_comb begin
      mag   = (2 * N)'(prod2) << sh2;
      trunc = mag >> POST_SHIFT;
      res   = neg2 ? -trunc : trunc;   // negating zero yields zero
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3    <= 1'b0;
         out_p <= '0;
      end else if (rdy3) begin
         v3 <= v2;
         if (v2) out_p <= res;
      end
   end

endmodule

// File: tb/tb_drum_mul_pipe.sv
`timescale 1ns/1ps
// Directed-vector bench for drum_mul_pipe (N=16, K=5, POST_SHIFT=8).
// Expected products are hand-computed constants. The random streaming
// section uses an independent arithmetic DRUM model. A negedge monitor
// scoreboards every accepted pair against every emitted result, in order.
module tb_drum_mul_pipe;
   localparam int N  = 16;
   localparam int K  = 5;
   localparam int PS = 8;
`ifdef DRUM_MUL_EXACT_EN
   localparam longint EXP_1000_EXACT = 3906;
`else
   localparam longint EXP_1000_EXACT = 3844;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   in_a = '0;
   logic [N-1:0]   in_b = '0;
   logic           in_exact = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*N-1:0] out_p;
   logic           busy;

   longint drv_exp = 0;
   longint exp_q[$];
   int     n_checks = 0;
   int     n_pass = 0;
   int     n_out = 0;

   drum_mul_pipe #(.N(N), .K(K), .POST_SHIFT(PS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_exact  (in_exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Independent DRUM reference: plain integer arithmetic on magnitudes.
   function automatic void enc(input longint v, output longint sel, output int sh);
      longint m;
      int     p;
      m = (v < 0) ? -v : v;
      if (m < (longint'(1) << K)) begin
         sel = m;
         sh  = 0;
      end else begin
         p = 0;
         while ((m >> (p + 1)) != 0) p++;
         sh  = p - K + 1;
         sel = (m >> sh) | 1;
      end
   endfunction

   function automatic longint drum_ref(input int a, input int b);
      longint sa, sb, r;
      int     ha, hb;
      enc(a, sa, ha);
      enc(b, sb, hb);
      r = ((sa * sb) << (ha + hb)) >> PS;
      return ((a < 0) != (b < 0)) ? -r : r;
   endfunction

   // Transfers happen at the following posedge; inputs are stable here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check("out_p", longint'($signed(out_p)), exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(drv_exp);
      end
   end

   task automatic drive(input int a, input int b, input logic ex, input longint e);
      in_a     = N'(a);
      in_b     = N'(b);
      in_exact = ex;
      drv_exp  = e;
      in_valid = 1'b1;
   endtask

   // Offer one pair and hold it until accepted (bounded).
   task automatic send1(input int a, input int b, input logic ex, input longint e);
      int t;
      t = 0;
      drive(a, b, ex, e);
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 40) begin
         @(negedge clk);
         t++;
      end
      check(tag, busy, 0);
      @(posedge clk);
      #1;
   endtask

   // Single pair, then out_valid must rise on the third edge after acceptance.
   task automatic latency_probe(input string pfx, input int a, input int b, input longint e);
      drive(a, b, 1'b0, e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk) check({pfx, "_e1"}, out_valid, 0);
      @(negedge clk) check({pfx, "_e2"}, out_valid, 0);
      @(negedge clk) check({pfx, "_e3"}, out_valid, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   int     bp_a[5] = '{100, -100, 1000, 300, 32767};
   int     bp_b[5] = '{100, 100, 1000, -7, 32767};
   longint bp_e[5] = '{39, -39, 3844, -8, 3936256};
   int     rs_a[64];
   int     rs_b[64];

   initial begin
      int          idx, t, n0, stalls, cyc;
      logic [2*N-1:0] held;
      logic [15:0] ra;

      // ---- asynchronous reset ----
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_p", out_p, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // ---- basic + latency ----
      out_ready = 1'b1;
      latency_probe("lat", 100, 100, 39);

      // ---- directed sign / zero / truncation vectors ----
      send1(-100, 100, 1'b0, -39);
      send1(0, -32768, 1'b0, 0);
      send1(-100, -100, 1'b0, 39);
      send1(1000, 1000, 1'b0, 3844);
      send1(1000, 1000, 1'b1, EXP_1000_EXACT);
      send1(300, -7, 1'b0, -8);
      send1(-32768, -32768, 1'b0, 4734976);
      send1(32767, -1, 1'b0, -124);
      send1(3, 5, 1'b0, 0);
      wait_idle("dir_idle");

      // ---- backpressure: 5 pairs offered, capacity is 3 ----
      out_ready = 1'b0;
      idx = 0;
      held = '0;
      for (int c = 0; c < 8; c++) begin
         drive(bp_a[idx], bp_b[idx], 1'b0, bp_e[idx]);
         @(negedge clk);
         if (in_ready) idx++;
         if (c == 3) held = out_p;
         @(posedge clk);
         #1;
      end
      check("bp_accepted", idx, 3);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold", out_p, held);
      check("bp_head", longint'($signed(out_p)), 39);
      n0 = n_out;
      out_ready = 1'b1;
      #1 check("bp_release_rdy", in_ready, 1);
      t = 0;
      while (idx < 5 && t < 20) begin
         drive(bp_a[idx], bp_b[idx], 1'b0, bp_e[idx]);
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      wait_idle("bp_idle");
      check("bp_drained", n_out - n0, 5);

      // ---- streaming: 64 random pairs, full throughput ----
      rs_a[0] = -32768; rs_b[0] = -32768;
      rs_a[1] = 32767;  rs_b[1] = -32768;
      for (int i = 2; i < 64; i++) begin
         ra = 16'($urandom);
         rs_a[i] = int'($signed(ra)) >>> $urandom_range(0, 15);
         ra = 16'($urandom);
         rs_b[i] = int'($signed(ra)) >>> $urandom_range(0, 15);
      end
      n0 = n_out;
      stalls = 0;
      idx = 0;
      cyc = 0;
      while (idx < 64 && cyc < 200) begin
         drive(rs_a[idx], rs_b[idx], 1'b0, drum_ref(rs_a[idx], rs_b[idx]));
         @(negedge clk);
         if (in_ready) idx++;
         else stalls++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_stalls", stalls, 0);
      repeat (3) @(negedge clk);
      #1 check("stream_count", n_out - n0, 64);
      @(posedge clk);
      #1;

      // ---- reset with three entries in flight ----
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(bp_a[c], bp_b[c], 1'b0, bp_e[c]);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("mf_full_valid", out_valid, 1);
      check("mf_full_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mf_out_valid", out_valid, 0);
      check("mf_out_p", out_p, 0);
      check("mf_busy", busy, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check("mf_in_ready", in_ready, 1);
      latency_probe("mf_lat", 1000, 1000, 3844);
      wait_idle("final_idle");
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
